// File: rtl/mem_arb_subsys_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_subsys_if
// Description : Bus bundle between the pipeline requesters (I and D ports)
//               and the unified memory subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_subsys_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   // Instruction port
   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic [DATA_W-1:0]     i_rdata;
   logic                  i_ack;
   // Data port
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_be;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_ack;
   // Pipeline freeze
   logic                  stall;

   // Memory side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
      output i_rdata, i_ack, d_rdata, d_ack, stall
   );

   // Requester side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
      input  i_rdata, i_ack, d_rdata, d_ack, stall
   );
endinterface
`default_nettype wire

// File: rtl/mem_arb_subsys.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_subsys
// Description : Unified single-ported word RAM shared by an instruction port
//               and a data port. Arbitrated access with programmable wait
//               states, req/ack handshake and a pipeline stall output.
//               Optional macro ARB_RR_EN selects round-robin conflict
//               resolution; otherwise the D port has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_subsys #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   mem_arb_subsys_if.slave  bus
);

   localparam int         c_BE_W     = DATA_W / 8;
   localparam int         c_IDX_W    = $clog2(DEPTH);
   localparam bit         c_HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [3:0] c_WAIT_M1  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [3:0]           r_cnt, w_cnt_nxt;
   logic                 r_grant_d, w_grant_d_nxt;   // 1 = D port owns the access
   logic                 r_last_d, w_last_d_nxt;     // last grant went to D
   logic                 w_any_req;
   logic                 w_win_d;
   logic                 w_enter_ack;
   logic                 w_sel_d;
   logic                 w_mem_we;
   logic [c_IDX_W-1:0]   w_i_idx;
   logic [c_IDX_W-1:0]   w_d_idx;
   logic                 r_i_ack, r_d_ack;
   logic [DATA_W-1:0]    r_i_rdata, r_d_rdata;
   logic [DATA_W-1:0]    r_mem [DEPTH];

   // Word index: byte offset and high bits dropped, so addresses alias modulo DEPTH
   assign w_i_idx   = bus.i_addr[c_IDX_W+1:2];
   assign w_d_idx   = bus.d_addr[c_IDX_W+1:2];
   assign w_any_req = bus.i_req | bus.d_req;

   // Bits that do not take part in addressing
   logic w_unused_bits;
   assign w_unused_bits = ^{bus.i_addr[ADDR_W-1:c_IDX_W+2], bus.i_addr[1:0],
                            bus.d_addr[ADDR_W-1:c_IDX_W+2], bus.d_addr[1:0]};

`ifndef ARB_RR_EN
   // With fixed priority the last-grant flag is tracked but never consulted
   logic w_unused_last;
   assign w_unused_last = r_last_d;
`endif

   // Arbitration: pick the winner among the ports requesting in IDLE
   always_comb begin
      w_win_d = 1'b0;
      if (bus.d_req && !bus.i_req) begin
         w_win_d = 1'b1;
      end else if (bus.d_req && bus.i_req) begin
`ifdef ARB_RR_EN
         w_win_d = ~r_last_d;
`else
         w_win_d = 1'b1;
`endif
      end
   end

   // Next-state logic: IDLE -> (BUSY) -> ACK -> IDLE
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_grant_d_nxt = r_grant_d;
      w_last_d_nxt  = r_last_d;
      w_enter_ack   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_grant_d_nxt = w_win_d;
               w_last_d_nxt  = w_win_d;
               if (c_HAS_WAIT) begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = c_WAIT_M1;
               end else begin
                  w_state_nxt = S_ACK;
                  w_enter_ack = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_ACK;
               w_enter_ack = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_ACK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // With zero wait states the grant register is not yet loaded on the
   // edge entering ACK, so the live arbitration result is used there.
   assign w_sel_d  = (r_state == S_IDLE) ? w_win_d : r_grant_d;
   // Reset gating keeps an access that is being torn down from committing
   assign w_mem_we = w_enter_ack & w_sel_d & bus.d_we & reset;

   // FSM state, wait counter and grant bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_grant_d <= 1'b0;
         r_last_d  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_grant_d <= w_grant_d_nxt;
         r_last_d  <= w_last_d_nxt;
      end
   end

   // Completion pulses and read-data capture on the edge entering ACK
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_i_ack <= w_enter_ack & ~w_sel_d;
         r_d_ack <= w_enter_ack &  w_sel_d;
         if (w_enter_ack && !w_sel_d) begin
            r_i_rdata <= r_mem[w_i_idx];
         end
         if (w_enter_ack && w_sel_d && !bus.d_we) begin
            r_d_rdata <= r_mem[w_d_idx];
         end
      end
   end

   // Byte-enabled RAM write; contents survive reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int k = 0; k < c_BE_W; k++) begin
            if (bus.d_be[k]) begin
               r_mem[w_d_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
            end
         end
      end
   end

   assign bus.i_ack   = r_i_ack;
   assign bus.d_ack   = r_d_ack;
   assign bus.i_rdata = r_i_rdata;
   assign bus.d_rdata = r_d_rdata;
   assign bus.stall   = (bus.i_req & ~r_i_ack) | (bus.d_req & ~r_d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_subsys.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb_subsys
// Description : Directed self-checking bench for mem_arb_subsys
//               (WAIT_CYCLES=2, DEPTH=256). Expectations for arbitration
//               follow ARB_RR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb_subsys;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   int   n_fail;

   mem_arb_subsys_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   mem_arb_subsys #(
      .DATA_W      (32),
      .DEPTH       (256),
      .ADDR_W      (32),
      .WAIT_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next cycle; sample point sits 2 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One D-port access; returns the cycle at which d_ack was seen (-1 on timeout)
   task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output int lat);
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      bus.d_be    = be;
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         tick();
         if (bus.d_ack === 1'b1) lat = c;
      end
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();
   endtask

   // One I-port read; returns the ack cycle (-1 on timeout)
   task automatic i_access(input logic [31:0] a, output int lat);
      bus.i_req  = 1'b1;
      bus.i_addr = a;
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         tick();
         if (bus.i_ack === 1'b1) lat = c;
      end
      bus.i_req = 1'b0;
      tick();
   endtask

   initial begin
      int lat;
      int i_cyc, d_cyc;
      int i_cnt, d_cnt;
      int ack_seen;
      logic [31:0] exp_i_cyc, exp_d_cyc, exp_i_cnt, exp_d_cnt;

      n_total = 0; n_pass = 0; n_fail = 0;
      reset       = 1'b0;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.d_be    = '0;

      // ---- Reset state ----
      tick(); tick();
      chk("rst_i_ack",   {31'd0, bus.i_ack}, 32'd0);
      chk("rst_d_ack",   {31'd0, bus.d_ack}, 32'd0);
      chk("rst_i_rdata", bus.i_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_stall",   {31'd0, bus.stall}, 32'd0);
      reset = 1'b1;
      tick();

      // ---- Full-word write then read-back, latency WAIT_CYCLES+1 ----
      d_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat);
      chk("wr_latency", lat, 32'd3);
      chk("wr_keeps_d_rdata", bus.d_rdata, 32'd0);
      d_access(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat);
      chk("rd_latency", lat, 32'd3);
      chk("rd_0x10", bus.d_rdata, 32'hDEAD_BEEF);

      // ---- Byte enables and aliasing ----
      d_access(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, lat);
      d_access(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat);
      chk("be0_merge", bus.d_rdata, 32'hDEAD_BEAA);
      d_access(1'b0, 32'h0000_0410, 32'h0, 4'h0, lat);
      chk("alias_0x410", bus.d_rdata, 32'hDEAD_BEAA);
      d_access(1'b1, 32'hFFFF_F413, 32'h0055_0000, 4'b0100, lat);
      d_access(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat);
      chk("be2_alias_wr", bus.d_rdata, 32'hDE55_BEAA);

      // ---- I-port read ----
      i_access(32'h0000_0010, lat);
      chk("i_latency", lat, 32'd3);
      chk("i_rdata", bus.i_rdata, 32'hDE55_BEAA);
      chk("d_rdata_hold", bus.d_rdata, 32'hDE55_BEAA);

      // Last grant ends on D before the conflict test
      d_access(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, lat);

      // ---- Simultaneous requests ----
`ifdef ARB_RR_EN
      exp_i_cyc = 32'd3; exp_d_cyc = 32'd7;
`else
      exp_i_cyc = 32'd7; exp_d_cyc = 32'd3;
`endif
      bus.i_req  = 1'b1; bus.i_addr = 32'h0000_0010;
      bus.d_req  = 1'b1; bus.d_we   = 1'b0; bus.d_addr = 32'h0000_0020;
      #1;
      chk("conf_stall_c0", {31'd0, bus.stall}, 32'd1);
      i_cyc = -1; d_cyc = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("conf_stall_c%0d", c), {31'd0, bus.stall}, (c < 7) ? 32'd1 : 32'd0);
         if (bus.i_ack === 1'b1 && i_cyc < 0) begin i_cyc = c; bus.i_req = 1'b0; end
         if (bus.d_ack === 1'b1 && d_cyc < 0) begin d_cyc = c; bus.d_req = 1'b0; end
      end
      chk("conf_i_ack_cyc", i_cyc, exp_i_cyc);
      chk("conf_d_ack_cyc", d_cyc, exp_d_cyc);
      chk("conf_i_rdata", bus.i_rdata, 32'hDE55_BEAA);
      chk("conf_d_rdata", bus.d_rdata, 32'h1234_5678);
      tick();

      // ---- Both requests held high for four accesses ----
`ifdef ARB_RR_EN
      exp_i_cnt = 32'd2; exp_d_cnt = 32'd2;
`else
      exp_i_cnt = 32'd0; exp_d_cnt = 32'd4;
`endif
      bus.i_req = 1'b1;
      bus.d_req = 1'b1;
      i_cnt = 0; d_cnt = 0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (bus.i_ack === 1'b1) i_cnt++;
         if (bus.d_ack === 1'b1) d_cnt++;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      chk("hold_i_acks", i_cnt, exp_i_cnt);
      chk("hold_d_acks", d_cnt, exp_d_cnt);

      // ---- Reset during BUSY aborts the write ----
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0020;
      bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'hF;
      tick();
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_d_ack",   {31'd0, bus.d_ack}, 32'd0);
      chk("mid_rst_i_rdata", bus.i_rdata, 32'd0);
      chk("mid_rst_d_rdata", bus.d_rdata, 32'd0);
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      ack_seen = 0;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (bus.d_ack === 1'b1 || bus.i_ack === 1'b1) ack_seen++;
      end
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.d_ack === 1'b1 || bus.i_ack === 1'b1) ack_seen++;
      end
      chk("abort_no_ack", ack_seen, 32'd0);
      chk("post_rst_stall_lo", {31'd0, bus.stall}, 32'd0);
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0020;
      #1;
      chk("post_rst_stall_hi", {31'd0, bus.stall}, 32'd1);
      i_access(32'h0000_0020, lat);
      chk("abort_i_rd", bus.i_rdata, 32'h1234_5678);
      d_access(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat);
      chk("abort_d_rd", bus.d_rdata, 32'h1234_5678);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
